seq_detect_monitor: RTL
=======================

Name: seq_detect_monitor

Overview:
- Downstream consumer of the 11101 Moore sequence detector.
- Takes the detector's y output as det_in and produces a 1-cycle detection pulse, a saturating detection count, inter-detection gap statistics and a windowed-rate alarm.
- Sits between the detector and the status/debug readout logic.

Parameters:
- COUNT_W, 8: width of det_count and win_count.
- GAP_W, 8: width of the gap counter, last_gap and min_gap.
- WIN_LEN, 64: window length in clk cycles, >= 2.
- THRESH, 4: detections per window at or above which alarm is set, >= 1.

Ports:
- clk, input, 1: rising-edge clock, single clock domain.
- rst, input, 1: asynchronous active-low reset.
- det_in, input, 1: detector y output, synchronous to clk.
- enable, input, 1: monitoring enable.
- clr, input, 1: synchronous clear of statistics and alarm.
- det_pulse, output, 1: registered 1-cycle pulse per det_in rising edge.
- det_count, output, COUNT_W: total detections, saturating.
- overflow, output, 1: sticky flag; det_count reached max and a further edge arrived.
- last_gap, output, GAP_W: cycles between the two most recent detections.
- min_gap, output, GAP_W: smallest gap seen since reset/clr.
- gap_valid, output, 1: at least two detections seen since reset/clr.
- win_count, output, COUNT_W: detection count of the last completed window.
- alarm, output, 1: sticky; some completed window had >= THRESH detections.

Behaviour:
- Reset (rst=0, async): det_pulse=0, det_count=0, overflow=0, last_gap=0, min_gap=all-ones, gap_valid=0, win_count=0, alarm=0. Internal det_d=0, gap_cnt=0, seen_one=0, window FSM=W_IDLE. Reset asserted mid-window aborts it; no partial win_count is published.
- Edge detect:
  - det_d <= det_in every cycle, regardless of enable.
  - edge = det_in & ~det_d & enable & ~clr.
  - det_pulse <= edge, so latency is 1 cycle from det_in rising to det_pulse high.
  - det_in held high produces exactly one edge.
- Detection count:
  - On edge, if det_count < max: det_count+1.
  - Else hold at max and set overflow.
- Gap counter:
  - When enable=1, gap_cnt increments each cycle and saturates at all-ones.
  - On edge: if seen_one, last_gap <= gap_cnt+1 (saturating), min_gap <= min(min_gap, gap_cnt+1), gap_valid <= 1. Then gap_cnt <= 0 and seen_one <= 1.
  - Two edges k cycles apart give last_gap = k.
  - enable=0 freezes gap_cnt.
- Window FSM (states W_IDLE, W_RUN, W_EVAL):
  - W_IDLE: enable=1 -> W_RUN with tmr=0 and wcnt=0. Stays in W_IDLE while enable=0.
  - W_RUN: tmr increments. wcnt increments (saturating) on edge. When tmr == WIN_LEN-1 -> W_EVAL. enable=0 -> W_IDLE, window discarded.
  - W_EVAL (1 cycle): win_count <= wcnt; alarm <= alarm | (wcnt >= THRESH). Then -> W_RUN with tmr=0, and wcnt=1 if edge this cycle, else 0. enable=0 -> W_IDLE after the publish.
  - Window period is WIN_LEN+1 cycles including the W_EVAL cycle; an edge in W_EVAL counts toward the next window.
- clr (synchronous, priority over edge):
  - Same values as reset, except det_d keeps sampling.
  - FSM -> W_IDLE, which re-enters W_RUN next cycle if enable=1.
  - An edge coincident with clr is dropped.
- Unsigned arithmetic throughout. Every compare is done at the full register width.

Decomposition:
- Shared package seq_det_pkg: window-state enum (W_IDLE, W_RUN, W_EVAL) and default width constants, reused by the detector stage.
- One natural sub-module: seq_edge_pulse, holding the det_d register, edge gating and det_pulse register.

Test Plan:
- Reset, enable=1, det_in high for cycles 10-12 -> det_pulse high only in cycle 11; det_count=1; gap_valid=0.
- Edges at cycles 20, 25, 40 -> last_gap=15, min_gap=5, gap_valid=1, det_count=3.
- WIN_LEN=64, THRESH=4: 4 edges in one window -> at W_EVAL, win_count=4, alarm=1. Next window with 1 edge -> win_count=1, alarm stays 1.
- COUNT_W=3: 9 edges -> det_count=7, overflow=1 after the 8th edge.
- clr coincident with an edge -> no det_pulse, all statistics zeroed, min_gap=all-ones.
- rst low mid-window with 3 edges pending -> all outputs at reset values immediately, and win_count stays 0 after release.

Source files
------------

// File: rtl/seq_det_pkg.sv
`default_nettype none
// ============================================================================
// Module : seq_det_pkg
// Brief  : Shared window-state encoding and default widths for the 11101
//          detector monitor chain.
// Rev    : 1.0
// ============================================================================
package seq_det_pkg;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_RUN  = 2'd1,
        W_EVAL = 2'd2
    } win_state_t;

    localparam int DEF_COUNT_W = 8;
    localparam int DEF_GAP_W   = 8;
    localparam int DEF_WIN_LEN = 64;
    localparam int DEF_THRESH  = 4;

endpackage
`default_nettype wire

// File: rtl/seq_edge_pulse.sv
`default_nettype none
// ============================================================================
// Module : seq_edge_pulse
// Brief  : Rising-edge detect on the detector output with enable/clear gating
//          and a registered one-cycle pulse.
// Rev    : 1.0
// ============================================================================
module seq_edge_pulse
    import seq_det_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic det_in,
    input  logic enable,
    input  logic clr,
    output logic det_edge,
    output logic det_pulse
);

    logic det_q;
    logic det_pulse_q;

    // det_q samples every cycle so a level held across clr/disable never re-fires
    assign det_edge  = det_in & ~det_q & enable & ~clr;
    assign det_pulse = det_pulse_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            det_q       <= 1'b0;
            det_pulse_q <= 1'b0;
        end else begin
            det_q       <= det_in;
            det_pulse_q <= det_edge;
        end
    end

endmodule
`default_nettype wire

// File: rtl/seq_detect_monitor.sv
`default_nettype none
// ============================================================================
// Module : seq_detect_monitor
// Brief  : Detection pulse, saturating count, gap statistics and windowed-rate
//          alarm for the 11101 sequence detector output.
// Rev    : 1.0
// ============================================================================
module seq_detect_monitor
    import seq_det_pkg::*;
#(
    parameter int COUNT_W = DEF_COUNT_W,
    parameter int GAP_W   = DEF_GAP_W,
    parameter int WIN_LEN = DEF_WIN_LEN,
    parameter int THRESH  = DEF_THRESH
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               det_in,
    input  logic               enable,
    input  logic               clr,
    output logic               det_pulse,
    output logic [COUNT_W-1:0] det_count,
    output logic               overflow,
    output logic [GAP_W-1:0]   last_gap,
    output logic [GAP_W-1:0]   min_gap,
    output logic               gap_valid,
    output logic [COUNT_W-1:0] win_count,
    output logic               alarm
);

    localparam int                 TMR_W    = (WIN_LEN > 1) ? $clog2(WIN_LEN) : 1;
    localparam logic [TMR_W-1:0]   TMR_LAST = TMR_W'(WIN_LEN - 1);
    localparam logic [COUNT_W-1:0] THRESH_C = COUNT_W'(THRESH);

    logic det_edge;

    seq_edge_pulse u_edge (
        .clk       (clk),
        .rst       (rst),
        .det_in    (det_in),
        .enable    (enable),
        .clr       (clr),
        .det_edge  (det_edge),
        .det_pulse (det_pulse)
    );

    logic [COUNT_W-1:0] det_count_q;
    logic               overflow_q;
    logic [GAP_W-1:0]   gap_cnt_q, last_gap_q, min_gap_q;
    logic               gap_valid_q, seen_one_q;
    logic [GAP_W-1:0]   gap_plus1;

    assign gap_plus1 = (gap_cnt_q == '1) ? gap_cnt_q : gap_cnt_q + GAP_W'(1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            det_count_q <= '0;
            overflow_q  <= 1'b0;
            gap_cnt_q   <= '0;
            last_gap_q  <= '0;
            min_gap_q   <= '1;
            gap_valid_q <= 1'b0;
            seen_one_q  <= 1'b0;
        end else if (clr) begin
            det_count_q <= '0;
            overflow_q  <= 1'b0;
            gap_cnt_q   <= '0;
            last_gap_q  <= '0;
            min_gap_q   <= '1;
            gap_valid_q <= 1'b0;
            seen_one_q  <= 1'b0;
        end else if (det_edge) begin
            if (det_count_q != '1) det_count_q <= det_count_q + COUNT_W'(1);
            else                   overflow_q  <= 1'b1;
            if (seen_one_q) begin
                last_gap_q  <= gap_plus1;
                if (gap_plus1 < min_gap_q) min_gap_q <= gap_plus1;
                gap_valid_q <= 1'b1;
            end
            gap_cnt_q  <= '0;
            seen_one_q <= 1'b1;
        end else if (enable) begin
            gap_cnt_q <= gap_plus1;
        end
    end

    win_state_t         state_q, state_d;
    logic [TMR_W-1:0]   tmr_q, tmr_d;
    logic [COUNT_W-1:0] wcnt_q, wcnt_d;
    logic [COUNT_W-1:0] win_count_q, win_count_d;
    logic               alarm_q, alarm_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= W_IDLE;
            tmr_q       <= '0;
            wcnt_q      <= '0;
            win_count_q <= '0;
            alarm_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            tmr_q       <= tmr_d;
            wcnt_q      <= wcnt_d;
            win_count_q <= win_count_d;
            alarm_q     <= alarm_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        tmr_d       = tmr_q;
        wcnt_d      = wcnt_q;
        win_count_d = win_count_q;
        alarm_d     = alarm_q;
        if (clr) begin
            state_d     = W_IDLE;
            tmr_d       = '0;
            wcnt_d      = '0;
            win_count_d = '0;
            alarm_d     = 1'b0;
        end else begin
            case (state_q)
                W_IDLE: begin
                    if (enable) begin
                        state_d = W_RUN;
                        tmr_d   = '0;
                        wcnt_d  = '0;
                    end
                end
                W_RUN: begin
                    if (!enable) begin
                        state_d = W_IDLE;
                    end else begin
                        tmr_d = tmr_q + TMR_W'(1);
                        if (det_edge && (wcnt_q != '1)) wcnt_d = wcnt_q + COUNT_W'(1);
                        if (tmr_q == TMR_LAST) state_d = W_EVAL;
                    end
                end
                W_EVAL: begin
                    // An edge landing in the publish cycle opens the next window
                    win_count_d = wcnt_q;
                    alarm_d     = alarm_q | (wcnt_q >= THRESH_C);
                    tmr_d       = '0;
                    wcnt_d      = det_edge ? COUNT_W'(1) : '0;
                    state_d     = enable ? W_RUN : W_IDLE;
                end
                default: state_d = W_IDLE;
            endcase
        end
    end

    assign det_count = det_count_q;
    assign overflow  = overflow_q;
    assign last_gap  = last_gap_q;
    assign min_gap   = min_gap_q;
    assign gap_valid = gap_valid_q;
    assign win_count = win_count_q;
    assign alarm     = alarm_q;

endmodule
`default_nettype wire
